// File: rtl/serial_master_port.sv
// Master-side serial bus port: takes one parallel read/write command, requests
// the bus, serializes the frame, collects read data and returns one response.
module serial_master_port #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              frame_active_o,
  output logic              sdata_o,
  output logic              svalid_o,
  input  logic              sdata_i,
  input  logic              svalid_i
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               write_q, write_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [CNT_W-1:0]   tx_last;
  logic [DATA_W-1:0]  rx_shift;

  assign tx_last  = write_q ? CNT_W'(FRAME_W - 1) : CNT_W'(ADDR_W);
  assign rx_shift = {sdata_i, rx_q[DATA_W-1:1]};

  // NOTE: every next-state variable gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    rx_d      = rx_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          write_d   = cmd_write_i;
          tx_d      = {cmd_wdata_i, cmd_addr_i, cmd_write_i};
          bit_cnt_d = '0;
          idle_d    = '0;
          rx_d      = '0;
          err_d     = 1'b0;
          rdata_d   = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt_i) state_d = S_TX;
      end
      S_TX: begin
        if (!gnt_i) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          tx_d      = tx_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == tx_last) begin
            bit_cnt_d = '0;
            state_d   = write_q ? S_RESP : S_RX;
          end
        end
      end
      S_RX: begin
        if (!gnt_i) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (svalid_i) begin
          // A valid bit wins over a coincident timeout.
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          idle_d    = '0;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            err_d   = 1'b0;
            rdata_d = rx_shift;
            state_d = S_RESP;
          end
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is asynchronous so a mid-frame reset releases the bus at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      tx_q      <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      tx_q      <= tx_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cmd_ready_o    = (state_q == S_IDLE);
  assign req_o          = (state_q == S_REQ) || (state_q == S_TX) || (state_q == S_RX);
  assign frame_active_o = (state_q == S_TX) || (state_q == S_RX);
  assign svalid_o       = (state_q == S_TX);
  assign sdata_o        = (state_q == S_TX) && tx_q[0];
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_err_o      = err_q;
  assign rsp_rdata_o    = rdata_q;

endmodule
